// File: rtl/imuldiv_int_div_iterative.sv
// ---------------------------------------------------------------------------
// imuldiv_int_div_iterative
//
// Iterative restoring integer divider. It produces one quotient bit per cycle.
// A request is accepted in IDLE. The divider then spends WIDTH cycles in CALC
// and holds the packed {remainder, quotient} in DONE until the response is
// taken.
//
// Optional feature macro: IMULDIV_DIV_SIGNED_EN
//   defined   : divreq_msg_fn selects unsigned (0) or signed (1) division.
//   undefined : every request is unsigned and divreq_msg_fn is ignored.
//
// Ports
//   clk                 clock, all state updates on posedge
//   reset               synchronous, active-high reset
//   divreq_msg_a        dividend (WIDTH)
//   divreq_msg_b        divisor (WIDTH)
//   divreq_msg_fn       0 = unsigned, 1 = signed
//   divreq_val/rdy      request handshake
//   divresp_msg_result  {remainder, quotient} (2*WIDTH)
//   divresp_val/rdy     response handshake
// ---------------------------------------------------------------------------
module imuldiv_int_div_iterative #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     divreq_msg_a,
    input  logic [WIDTH-1:0]     divreq_msg_b,
    input  logic                 divreq_msg_fn,
    input  logic                 divreq_val,
    output logic                 divreq_rdy,
    output logic [2*WIDTH-1:0]   divresp_msg_result,
    output logic                 divresp_val,
    input  logic                 divresp_rdy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // {partial remainder (WIDTH+1), quotient/dividend (WIDTH)}
    logic [2*WIDTH:0]   rq_q, rq_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [WIDTH-1:0]   aorig_q, aorig_d;
    logic               dz_q, dz_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH:0]   sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quo, rem, quo_out, rem_out;

`ifdef IMULDIV_DIV_SIGNED_EN
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               a_neg, b_neg;

    always_comb begin
        a_neg = divreq_msg_fn & divreq_msg_a[WIDTH-1];
        b_neg = divreq_msg_fn & divreq_msg_b[WIDTH-1];
        // -(-2^(W-1)) wraps to the same bit pattern, which is the correct
        // unsigned magnitude 2^(W-1).
        a_mag = a_neg ? -divreq_msg_a : divreq_msg_a;
        b_mag = b_neg ? -divreq_msg_b : divreq_msg_b;
    end
`else
    logic               unused_fn;
    assign unused_fn = divreq_msg_fn;

    always_comb begin
        a_mag = divreq_msg_a;
        b_mag = divreq_msg_b;
    end
`endif

    // One restoring step: shift, then trial-subtract the divisor from the upper half.
    always_comb begin
        sh   = rq_q << 1;
        diff = sh[2*WIDTH:WIDTH] - {1'b0, bmag_q};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rq_d        = rq_q;
        bmag_d      = bmag_q;
        aorig_d     = aorig_q;
        dz_d        = dz_q;
`ifdef IMULDIV_DIV_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        divreq_rdy  = 1'b0;
        divresp_val = 1'b0;

        case (state_q)
            IDLE: begin
                divreq_rdy = 1'b1;
                if (divreq_val) begin
                    state_d = CALC;
                    cnt_d   = CW'(WIDTH - 1);
                    rq_d    = {{(WIDTH+1){1'b0}}, a_mag};
                    bmag_d  = b_mag;
                    aorig_d = divreq_msg_a;
                    dz_d    = (divreq_msg_b == '0);
`ifdef IMULDIV_DIV_SIGNED_EN
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
`endif
                end
            end
            CALC: begin
                if (!diff[WIDTH]) rq_d = {diff, sh[WIDTH-1:1], 1'b1};
                else              rq_d = sh;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: begin
                divresp_val = 1'b1;
                if (divresp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rq_q    <= '0;
            bmag_q  <= '0;
            aorig_q <= '0;
            dz_q    <= 1'b0;
`ifdef IMULDIV_DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rq_q    <= rq_d;
            bmag_q  <= bmag_d;
            aorig_q <= aorig_d;
            dz_q    <= dz_d;
`ifdef IMULDIV_DIV_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
`endif
        end
    end

    // Result formation
    always_comb begin
        quo = rq_q[WIDTH-1:0];
        rem = rq_q[2*WIDTH-1:WIDTH];
`ifdef IMULDIV_DIV_SIGNED_EN
        quo_out = qneg_q ? -quo : quo;
        rem_out = rneg_q ? -rem : rem;
`else
        quo_out = quo;
        rem_out = rem;
`endif
        // A zero divisor overrides the datapath: the quotient is all ones and
        // the remainder is the untouched dividend, in both modes.
        if (dz_q) divresp_msg_result = {aorig_q, {WIDTH{1'b1}}};
        else      divresp_msg_result = {rem_out, quo_out};
    end

endmodule
